io_design_mux_seq: RTL and testbench
====================================

Name: io_design_mux_seq

Overview:
- Parametrised successor to the design-select IO mux. It routes one of NUM_DESIGNS user designs to the NUM_IO IO pads, or none.
- Switchovers are glitch-safe: on a select change, all pads are isolated (input mode) for a guard period, the incoming design gets a timed reset pulse, and only then is the design connected.
- Sits between the Caravel IO pads/LA and the user-design macros.

Parameters:
- NUM_DESIGNS, 8: number of design slots.
- NUM_IO, 38: pad count.
- SEL_W, 4: select width. Must satisfy 2**SEL_W > NUM_DESIGNS. Codes >= NUM_DESIGNS mean "none".
- SYNC_STAGES, 2: synchroniser depth on the LA select lines. Minimum 2.
- GUARD_CYCLES, 4: isolation cycles before the reset phase. Minimum 1.
- RST_CYCLES, 16: reset-pulse length applied to the incoming design. Minimum 1.

Ports:
- wb_clk_i, in, 1: the single clock.
- wb_rst_i, in, 1: asynchronous, active-high reset.
- io_in, in, NUM_IO: pad inputs, repeated to designs.
- io_out, out, NUM_IO: registered pad outputs.
- io_oeb, out, NUM_IO: registered pad output-enables (active-low).
- mux_sel_i, in, SEL_W: requested design (LA, asynchronous to wb_clk_i).
- sys_reset_enb_i, in, 1: low lets wb_rst_i propagate to all design resets.
- auto_reset_enb_i, in, 1: low holds every non-connected design in reset.
- design_reset_i, in, NUM_DESIGNS: direct per-design reset (LA).
- des_io_out_i, in, NUM_DESIGNS*NUM_IO: flattened design outputs. Slot k occupies bits [k*NUM_IO +: NUM_IO].
- des_io_oeb_i, in, NUM_DESIGNS*NUM_IO: flattened design oeb, same packing.
- des_io_in_o, out, NUM_IO: io_in repeated.
- des_clk_o, out, NUM_DESIGNS: wb_clk_i repeated.
- des_ena_o, out, NUM_DESIGNS: one-hot. High only for the connected design in RUN.
- des_rst_o, out, NUM_DESIGNS: combinational per-design reset.
- active_sel_o, out, SEL_W: currently connected code.
- busy_o, out, 1: high whenever state != RUN.

Behaviour:
Reset (wb_rst_i high, async):
- state=RUN, active_sel=ALL-ONES ("none"), target=ALL-ONES, counter=0.
- Synchroniser flops reset to all-ones.
- io_out=all-ones, io_oeb=all-ones, des_ena_o=0, busy_o=0.

Synchroniser:
- Each mux_sel_i bit passes through a SYNC_STAGES flop chain. sync_sel is the last stage.

States: RUN, ISOLATE, RESET.

- RUN:
  - If sync_sel == active_sel: hold.
  - Else: target<=sync_sel, counter<=GUARD_CYCLES-1, active_sel<=ALL-ONES, go to ISOLATE.
  - Pads take the isolated value on the next registered update.
- ISOLATE:
  - Pads forced to io_out=1, io_oeb=1. des_ena_o=0.
  - Counter decrements each cycle.
  - At counter==0:
    - If target >= NUM_DESIGNS: active_sel<=target, go to RUN (no reset phase).
    - Else: counter<=RST_CYCLES-1, go to RESET.
- RESET:
  - Pads stay isolated. seq_rst[target]=1.
  - At counter==0: active_sel<=target, go to RUN.
- Retarget (any non-RUN state, sync_sel != target): target<=sync_sel, counter<=GUARD_CYCLES-1, go to ISOLATE. The sequence restarts in full; partial reset pulses are abandoned.

Pad datapath:
- Pads register the next-value combinational mux on every wb_clk_i edge.
- In RUN with active_sel < NUM_DESIGNS: io_out/io_oeb <= slot[active_sel] next cycle.
- Otherwise: all-ones.
- Pad latency from design output to pad is 1 cycle.

Design resets (combinational):
- des_rst_o[k] = design_reset_i[k] | (wb_rst_i & ~sys_reset_enb_i) | seq_rst[k] | (~auto_reset_enb_i & ~des_ena_o[k]).

des_ena_o:
- des_ena_o[k] = (state==RUN) & (active_sel==k).

Switch latency:
- Requested select to des_ena_o high = SYNC_STAGES + 1 + GUARD_CYCLES + RST_CYCLES cycles.
- Pad data appears 1 cycle later.

Selecting the active code again:
- Selecting the already-active code is a no-op with no glitch.

Decomposition:
- Package io_mux_pkg holds:
  - state enum {RUN, ISOLATE, RESET};
  - SEL_NONE constant = all-ones;
  - helper function slot_bits(k) for flattened indexing.
- Sub-module io_mux_sync: a parametrised SYNC_STAGES-deep, WIDTH-wide synchroniser with async reset to a parameter value. It is instantiated once for mux_sel_i.

Test Plan:
All scenarios use the defaults.
1. Reset, then mux_sel_i=2, slot2 io_out=38'h15_5555_5555, io_oeb=0.
   - busy_o rises at cycle 3.
   - Pads are all-ones throughout isolation.
   - des_rst_o[2] is high for exactly 16 cycles.
   - des_ena_o=8'b0000_0100 at cycle 23; pads show slot2 values at cycle 24.
2. Running slot 2, mux_sel_i=5 mid-RESET of a 2→5 switch, then 6 at RESET cycle 8:
   - the sequence restarts;
   - des_rst_o[5] pulse is truncated;
   - des_rst_o[6] is high for a full 16 cycles;
   - active_sel_o=6.
3. mux_sel_i=15 from slot 0 → 4 guard cycles, no reset pulse, active_sel_o=15, pads all-ones, des_ena_o=0.
4. auto_reset_enb_i=0 in RUN on slot 1 → des_rst_o=8'b1111_1101. With auto_reset_enb_i=1 → des_rst_o=design_reset_i.
5. Pulse wb_rst_i mid-ISOLATE, sys_reset_enb_i=0:
   - all des_rst_o high asynchronously;
   - outputs return to reset values the same cycle;
   - on release, the sequence to the current select reruns.
6. A 1-cycle glitch on mux_sel_i shorter than the sync window, then settling to its original value → at most one aborted ISOLATE, final active_sel_o unchanged, no des_ena_o high on a wrong slot.

Source files
------------

// File: rtl/io_mux_pkg.sv
// Shared types and helpers for the sequenced design-select IO mux.
// Imported by the synchroniser and the top level.
package io_mux_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ISOLATE = 2'd1,
        ST_RESET   = 2'd2
    } io_mux_state_e;

    // Wide enough for any legal select width; the top level slices it down.
    localparam logic [15:0] SEL_NONE = 16'hFFFF;

    function automatic int slot_bits(input int k, input int num_io);
        return k * num_io;
    endfunction

endpackage

// File: rtl/io_mux_sync.sv
// Multi-stage flop synchroniser for a bus that is quasi-static, like the LA select.
// Resets asynchronously to a parameterised value.
module io_mux_sync
    import io_mux_pkg::*;
#(
    parameter int                STAGES  = 2,
    parameter int                WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/io_design_mux_seq.sv
// Routes one of NUM_DESIGNS user designs to the pads, with a guarded
// isolate -> reset -> connect sequence on every select change.
module io_design_mux_seq
    import io_mux_pkg::*;
#(
    parameter int NUM_DESIGNS  = 8,
    parameter int NUM_IO       = 38,
    parameter int SEL_W        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 4,
    parameter int RST_CYCLES   = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [NUM_IO-1:0]             io_in,
    output logic [NUM_IO-1:0]             io_out,
    output logic [NUM_IO-1:0]             io_oeb,
    input  logic [SEL_W-1:0]              mux_sel_i,
    input  logic                          sys_reset_enb_i,
    input  logic                          auto_reset_enb_i,
    input  logic [NUM_DESIGNS-1:0]        design_reset_i,
    input  logic [NUM_DESIGNS*NUM_IO-1:0] des_io_out_i,
    input  logic [NUM_DESIGNS*NUM_IO-1:0] des_io_oeb_i,
    output logic [NUM_IO-1:0]             des_io_in_o,
    output logic [NUM_DESIGNS-1:0]        des_clk_o,
    output logic [NUM_DESIGNS-1:0]        des_ena_o,
    output logic [NUM_DESIGNS-1:0]        des_rst_o,
    output logic [SEL_W-1:0]              active_sel_o,
    output logic                          busy_o,
    output logic [1:0]                    dbg_state_o
);

    localparam logic [SEL_W-1:0] SEL_ALL = SEL_NONE[SEL_W-1:0];
    localparam int CNT_MAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    io_mux_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]   r_target, w_target_nxt;
    logic [SEL_W-1:0]   r_active_sel, w_active_nxt;
    logic [SEL_W-1:0]   w_sync_sel;
    logic               w_target_none;
    logic               w_retarget;
    logic [NUM_DESIGNS-1:0] w_ena;
    logic [NUM_DESIGNS-1:0] w_seq_rst;
    logic [NUM_IO-1:0]  w_pad_out, w_pad_oeb;
    logic [NUM_IO-1:0]  r_pad_out, r_pad_oeb;

    io_mux_sync #(
        .STAGES  (SYNC_STAGES),
        .WIDTH   (SEL_W),
        .RST_VAL (SEL_ALL)
    ) u_sel_sync (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_d   (mux_sel_i),
        .o_q   (w_sync_sel)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_target     <= SEL_ALL;
            r_active_sel <= SEL_ALL;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_target     <= w_target_nxt;
            r_active_sel <= w_active_nxt;
        end
    end

    assign w_target_none = (int'(r_target) >= NUM_DESIGNS);
    assign w_retarget    = (w_sync_sel != r_target);

    // A select change while sequencing restarts the guard from scratch, so a
    // partially delivered reset pulse is never mistaken for a complete one.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_active_nxt = r_active_sel;
        unique case (r_state)
            ST_RUN: begin
                if (w_sync_sel != r_active_sel) begin
                    w_target_nxt = w_sync_sel;
                    w_cnt_nxt    = CNT_W'(GUARD_CYCLES - 1);
                    w_active_nxt = SEL_ALL;
                    w_state_nxt  = ST_ISOLATE;
                end
            end
            ST_ISOLATE: begin
                if (w_retarget) begin
                    w_target_nxt = w_sync_sel;
                    w_cnt_nxt    = CNT_W'(GUARD_CYCLES - 1);
                end else if (r_cnt == '0) begin
                    if (w_target_none) begin
                        w_active_nxt = r_target;
                        w_state_nxt  = ST_RUN;
                    end else begin
                        w_cnt_nxt    = CNT_W'(RST_CYCLES - 1);
                        w_state_nxt  = ST_RESET;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESET: begin
                if (w_retarget) begin
                    w_target_nxt = w_sync_sel;
                    w_cnt_nxt    = CNT_W'(GUARD_CYCLES - 1);
                    w_state_nxt  = ST_ISOLATE;
                end else if (r_cnt == '0) begin
                    w_active_nxt = r_target;
                    w_state_nxt  = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Enable and sequencer reset are one-hot by construction: codes at or
    // above NUM_DESIGNS never match any slot index.
    always_comb begin
        w_ena     = '0;
        w_seq_rst = '0;
        w_pad_out = '1;
        w_pad_oeb = '1;
        for (int k = 0; k < NUM_DESIGNS; k++) begin
            w_ena[k]     = (r_state == ST_RUN) && (r_active_sel == SEL_W'(k));
            w_seq_rst[k] = (r_state == ST_RESET) && (r_target == SEL_W'(k));
            if (w_ena[k]) begin
                w_pad_out = des_io_out_i[slot_bits(k, NUM_IO) +: NUM_IO];
                w_pad_oeb = des_io_oeb_i[slot_bits(k, NUM_IO) +: NUM_IO];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_pad_out <= '1;
            r_pad_oeb <= '1;
        end else begin
            r_pad_out <= w_pad_out;
            r_pad_oeb <= w_pad_oeb;
        end
    end

    assign io_out       = r_pad_out;
    assign io_oeb       = r_pad_oeb;
    assign des_io_in_o  = io_in;
    assign des_clk_o    = {NUM_DESIGNS{wb_clk_i}};
    assign des_ena_o    = w_ena;
    assign active_sel_o = r_active_sel;
    assign busy_o       = (r_state != ST_RUN);
    assign dbg_state_o  = r_state;

    // Resets stay combinational so a system reset reaches designs immediately.
    assign des_rst_o = design_reset_i
                     | {NUM_DESIGNS{wb_rst_i & ~sys_reset_enb_i}}
                     | w_seq_rst
                     | ({NUM_DESIGNS{~auto_reset_enb_i}} & ~w_ena);

endmodule

// File: tb/tb_io_design_mux_seq.sv
// Directed bench for io_design_mux_seq: select sequencing, retarget,
// "none" selection, reset gating, async reset and select glitches.
module tb_io_design_mux_seq;

    localparam int ND = 8;
    localparam int NIO = 38;
    localparam int SW = 4;
    localparam logic [NIO-1:0] ALL1 = '1;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic [NIO-1:0]    io_in;
    logic [NIO-1:0]    io_out, io_oeb;
    logic [SW-1:0]     mux_sel_i;
    logic              sys_reset_enb_i, auto_reset_enb_i;
    logic [ND-1:0]     design_reset_i;
    logic [ND*NIO-1:0] des_io_out_i, des_io_oeb_i;
    logic [NIO-1:0]    des_io_in_o;
    logic [ND-1:0]     des_clk_o, des_ena_o, des_rst_o;
    logic [SW-1:0]     active_sel_o;
    logic              busy_o;
    logic [1:0]        dbg_state_o;

    int total = 0;
    int bad   = 0;
    int cnt_a, cnt_b, cnt_c;
    logic prev_busy;

    io_design_mux_seq dut (
        .wb_clk_i         (wb_clk_i),
        .wb_rst_i         (wb_rst_i),
        .io_in            (io_in),
        .io_out           (io_out),
        .io_oeb           (io_oeb),
        .mux_sel_i        (mux_sel_i),
        .sys_reset_enb_i  (sys_reset_enb_i),
        .auto_reset_enb_i (auto_reset_enb_i),
        .design_reset_i   (design_reset_i),
        .des_io_out_i     (des_io_out_i),
        .des_io_oeb_i     (des_io_oeb_i),
        .des_io_in_o      (des_io_in_o),
        .des_clk_o        (des_clk_o),
        .des_ena_o        (des_ena_o),
        .des_rst_o        (des_rst_o),
        .active_sel_o     (active_sel_o),
        .busy_o           (busy_o),
        .dbg_state_o      (dbg_state_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic step();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        wb_rst_i         = 1'b1;
        io_in            = 38'h12_3456_789A;
        mux_sel_i        = 4'hF;
        sys_reset_enb_i  = 1'b1;
        auto_reset_enb_i = 1'b1;
        design_reset_i   = '0;
        for (int k = 0; k < ND; k++) begin
            des_io_out_i[k*NIO +: NIO] = 38'(k);
            des_io_oeb_i[k*NIO +: NIO] = 38'h3F_0000_0000 | 38'(k);
        end
        des_io_out_i[2*NIO +: NIO] = 38'h15_5555_5555;
        des_io_oeb_i[2*NIO +: NIO] = '0;

        // Reset state
        steps(3);
        chk("rst_io_out", io_out, ALL1);
        chk("rst_io_oeb", io_oeb, ALL1);
        chk("rst_ena", des_ena_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_active", active_sel_o, 4'hF);
        chk("rst_des_rst", des_rst_o, 0);
        chk("io_in_rep", des_io_in_o, 38'h12_3456_789A);
        chk("clk_rep", des_clk_o, 0);
        wb_rst_i = 1'b0;
        step();

        // 1: none -> slot 2
        mux_sel_i = 4'd2;
        cnt_a = 0; cnt_b = 0;
        for (int e = 1; e <= 24; e++) begin
            step();
            if (e == 2) chk("t1_busy_pre", busy_o, 0);
            if (e == 3) begin
                chk("t1_busy_rise", busy_o, 1);
                chk("t1_state_iso", dbg_state_o, 1);
            end
            if (e == 7) chk("t1_state_reset", dbg_state_o, 2);
            if (des_rst_o[2]) cnt_a++;
            if (e <= 23 && (io_out !== ALL1 || io_oeb !== ALL1)) cnt_b++;
            if (e == 22) chk("t1_ena_early", des_ena_o, 0);
            if (e == 23) chk("t1_ena", des_ena_o, 8'b0000_0100);
        end
        chk("t1_rst2_len", cnt_a, 16);
        chk("t1_pads_isolated", cnt_b, 0);
        chk("t1_io_out", io_out, 38'h15_5555_5555);
        chk("t1_io_oeb", io_oeb, 0);
        chk("t1_active", active_sel_o, 2);

        // 2: 2 -> 5, retarget to 6 at RESET cycle 8
        mux_sel_i = 4'd5;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (e == 15) mux_sel_i = 4'd6;
            if (des_rst_o[5]) cnt_a++;
            if (des_rst_o[6]) cnt_b++;
            if (e >= 3 && e <= 37 && des_ena_o !== 0) cnt_c++;
        end
        chk("t2_rst5_trunc", cnt_a, 11);
        chk("t2_rst6_full", cnt_b, 16);
        chk("t2_no_ena", cnt_c, 0);
        chk("t2_active", active_sel_o, 6);
        chk("t2_ena", des_ena_o, 8'b0100_0000);
        chk("t2_io_out", io_out, 38'd6);

        // 3: slot 0 -> none
        mux_sel_i = 4'd0;
        steps(24);
        chk("t3_active0", active_sel_o, 0);
        mux_sel_i = 4'hF;
        cnt_a = 0; cnt_b = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (busy_o) cnt_a++;
            if (des_rst_o !== 0) cnt_b++;
        end
        chk("t3_guard_len", cnt_a, 4);
        chk("t3_no_rst", cnt_b, 0);
        chk("t3_active", active_sel_o, 4'hF);
        chk("t3_io_out", io_out, ALL1);
        chk("t3_io_oeb", io_oeb, ALL1);
        chk("t3_ena", des_ena_o, 0);

        // 4: auto reset gating on slot 1
        mux_sel_i = 4'd1;
        steps(24);
        chk("t4_active", active_sel_o, 1);
        chk("t4_io_out", io_out, 38'd1);
        chk("t4_io_oeb", io_oeb, 38'h3F_0000_0001);
        auto_reset_enb_i = 1'b0;
        #1;
        chk("t4_auto_rst", des_rst_o, 8'b1111_1101);
        auto_reset_enb_i = 1'b1;
        design_reset_i   = 8'h30;
        #1;
        chk("t4_direct_rst", des_rst_o, 8'h30);
        design_reset_i = '0;
        @(negedge wb_clk_i);

        // 5: async reset mid-ISOLATE with system reset propagation
        mux_sel_i = 4'd3;
        steps(4);
        chk("t5_in_iso", dbg_state_o, 1);
        sys_reset_enb_i = 1'b0;
        wb_rst_i        = 1'b1;
        #1;
        chk("t5_all_rst", des_rst_o, 8'hFF);
        chk("t5_io_out", io_out, ALL1);
        chk("t5_io_oeb", io_oeb, ALL1);
        chk("t5_busy", busy_o, 0);
        chk("t5_active", active_sel_o, 4'hF);
        @(negedge wb_clk_i);
        wb_rst_i        = 1'b0;
        sys_reset_enb_i = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            step();
            if (e == 22) chk("t5_ena_early", des_ena_o, 0);
            if (e == 23) chk("t5_ena", des_ena_o, 8'b0000_1000);
        end
        chk("t5_io_out3", io_out, 38'd3);

        // 6: one-cycle glitch 3 -> 4 -> 3
        mux_sel_i = 4'd4;
        cnt_a = 0; cnt_b = 0;
        prev_busy = busy_o;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e == 1) mux_sel_i = 4'd3;
            if (des_ena_o !== 0 && des_ena_o !== 8'b0000_1000) cnt_a++;
            if (busy_o && !prev_busy) cnt_b++;
            prev_busy = busy_o;
        end
        chk("t6_wrong_ena", cnt_a, 0);
        chk("t6_one_abort", cnt_b, 1);
        chk("t6_active", active_sel_o, 3);
        chk("t6_ena", des_ena_o, 8'b0000_1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
